// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte sources.
// Tracks frame completion by counting baud ticks, since the transmitter reports no status.
module uart_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ID_W        = 2,
  parameter int FRAME_TICKS = 11
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   baud_rate_signal,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [8*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]     grant,
  output logic [7:0]             tx_data,
  output logic                   tx_start,
  output logic                   busy,
  output logic [ID_W-1:0]        active_id
);

  localparam int              ID_SPAN    = 1 << ID_W;
  localparam logic [ID_W-1:0] ID_LAST    = ID_W'(NUM_REQ - 1);
  localparam logic [3:0]      FRAME_LAST = 4'(FRAME_TICKS - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [7:0]           tx_data_q, tx_data_d;
  logic                 tx_start_q, tx_start_d;
  logic                 busy_q, busy_d;
  logic [ID_W-1:0]      active_id_q, active_id_d;

  logic [ID_SPAN-1:0]   req_pad_s;
  logic                 sel_found_s;
  logic [ID_W-1:0]      sel_id_s;
  logic [ID_W-1:0]      cand_s;
  logic [7:0]           sel_data_s;
  logic [NUM_REQ-1:0]   sel_onehot_s;

  // Round-robin pick: first set request after the last granted index, wrapping modulo NUM_REQ.
  always_comb begin
    req_pad_s   = ID_SPAN'(req);
    sel_found_s = 1'b0;
    sel_id_s    = '0;
    cand_s      = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand_s = ID_W'((int'(active_id_q) + i) % NUM_REQ);
      if (!sel_found_s && req_pad_s[cand_s]) begin
        sel_found_s = 1'b1;
        sel_id_s    = cand_s;
      end else begin
        sel_found_s = sel_found_s;
      end
    end
  end

  // Byte and one-hot grant for the selected requester.
  always_comb begin
    sel_data_s   = 8'h00;
    sel_onehot_s = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (ID_W'(j) == sel_id_s) begin
        sel_data_s      = req_data[8*j +: 8];
        sel_onehot_s[j] = 1'b1;
      end else begin
        sel_onehot_s[j] = 1'b0;
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    grant_d     = '0;
    tx_start_d  = 1'b0;
    tx_data_d   = tx_data_q;
    busy_d      = busy_q;
    active_id_d = active_id_q;
    case (state_q)
      ST_IDLE: begin
        if (sel_found_s) begin
          grant_d     = sel_onehot_s;
          tx_start_d  = 1'b1;
          tx_data_d   = sel_data_s;
          active_id_d = sel_id_s;
          busy_d      = 1'b1;
          cnt_d       = 4'd0;
          state_d     = ST_WAIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        // A tick in the start cycle is skipped: the transmitter is still idle then.
        if (baud_rate_signal && !tx_start_q) begin
          if (cnt_q == FRAME_LAST) begin
            cnt_d   = 4'd0;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      grant_q     <= '0;
      tx_data_q   <= 8'h00;
      tx_start_q  <= 1'b0;
      busy_q      <= 1'b0;
      active_id_q <= ID_LAST;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      grant_q     <= grant_d;
      tx_data_q   <= tx_data_d;
      tx_start_q  <= tx_start_d;
      busy_q      <= busy_d;
      active_id_q <= active_id_d;
    end
  end

  assign grant     = grant_q;
  assign tx_data   = tx_data_q;
  assign tx_start  = tx_start_q;
  assign busy      = busy_q;
  assign active_id = active_id_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: grant order, latency, frame tick counting and reset.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        baud_rate_signal;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  grant;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        busy;
  logic [1:0]  active_id;

  int n_chk = 0;
  int n_err = 0;
  logic prev_busy = 1'b0;

  uart_tx_arbiter #(.NUM_REQ(4), .ID_W(2), .FRAME_TICKS(11)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .baud_rate_signal (baud_rate_signal),
    .req              (req),
    .req_data         (req_data),
    .grant            (grant),
    .tx_data          (tx_data),
    .tx_start         (tx_start),
    .busy             (busy),
    .active_id        (active_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Each tick preceded by one idle cycle; returns just after the tick edge.
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      baud_rate_signal = 1'b1;
      step();
      baud_rate_signal = 1'b0;
    end
  endtask

  task automatic run_frame(input string tag, input logic [7:0] exp_data);
    ticks(10);
    chk({tag, "_busy_before_last"}, busy, 1'b1);
    chk({tag, "_data_held"}, tx_data, exp_data);
    ticks(1);
    chk({tag, "_busy_fall"}, busy, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
  endtask

  // Never start a frame while the previous one is still busy; grant never multi-hot.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && tx_start === 1'b1) chk("no_overlap", prev_busy, 1'b0);
    if (rst_n === 1'b1) chk("grant_onehot0", $onehot0(grant), 1'b1);
    prev_busy <= busy;
  end

  initial begin
    logic [3:0] exp_g [5];
    logic [7:0] exp_d [5];
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_d = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};

    rst_n = 1'b0; req = 4'b0000; req_data = 32'h0; baud_rate_signal = 1'b0;
    step(); step();
    chk("rst_grant", grant, 4'b0000);
    chk("rst_tx_start", tx_start, 1'b0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_active_id", active_id, 2'd3);
    rst_n = 1'b1;
    step();

    // Single request
    req = 4'b0001; req_data = 32'h0000_00A5;
    step();
    chk("single_grant", grant, 4'b0001);
    chk("single_start", tx_start, 1'b1);
    chk("single_data", tx_data, 8'hA5);
    chk("single_busy", busy, 1'b1);
    chk("single_id", active_id, 2'd0);
    req = 4'b0000;
    step();
    chk("single_start_pulse", tx_start, 1'b0);
    chk("single_grant_pulse", grant, 4'b0000);
    run_frame("single", 8'hA5);

    // Simultaneous requests after reset, back-to-back
    do_reset();
    req = 4'b0110; req_data = 32'h4433_2211;
    step();
    chk("simul_first", grant, 4'b0010);
    chk("simul_first_data", tx_data, 8'h22);
    req = 4'b0100;
    step();
    run_frame("simul1", 8'h22);
    chk("simul_gap", grant, 4'b0000);
    step();
    chk("simul_second", grant, 4'b0100);
    chk("simul_second_data", tx_data, 8'h33);
    chk("simul_second_id", active_id, 2'd2);
    req = 4'b0000;
    step();
    run_frame("simul2", 8'h33);

    // Fairness with all requesters asking continuously
    do_reset();
    req = 4'b1111;
    step();
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("fair_grant%0d", k), grant, exp_g[k]);
      chk($sformatf("fair_data%0d", k), tx_data, exp_d[k]);
      if (k == 4) req = 4'b0000;
      step();
      run_frame($sformatf("fair%0d", k), exp_d[k]);
      step();
    end
    chk("fair_end", grant, 4'b0000);

    // Tick coincident with the start cycle is not counted
    req = 4'b0001;
    step();
    chk("coinc_grant", grant, 4'b0001);
    baud_rate_signal = 1'b1; req = 4'b0000;
    step();
    baud_rate_signal = 1'b0;
    chk("coinc_start_low", tx_start, 1'b0);
    run_frame("coinc", 8'h11);

    // Reset in the middle of a frame
    req = 4'b0010;
    step();
    chk("midrst_grant", grant, 4'b0010);
    req = 4'b0000;
    step();
    ticks(5);
    chk("midrst_busy", busy, 1'b1);
    rst_n = 1'b0; req = 4'b1000;
    #1;
    chk("midrst_grant0", grant, 4'b0000);
    chk("midrst_start0", tx_start, 1'b0);
    chk("midrst_busy0", busy, 1'b0);
    chk("midrst_data0", tx_data, 8'h00);
    chk("midrst_id", active_id, 2'd3);
    step();
    rst_n = 1'b1;
    step();
    chk("postrst_grant", grant, 4'b1000);
    chk("postrst_data", tx_data, 8'h44);
    req = 4'b0000;
    step();

    // Request raised and withdrawn while busy gets no grant
    ticks(3);
    req = 4'b0001;
    ticks(2);
    req = 4'b0000;
    ticks(5);
    chk("wd_busy", busy, 1'b1);
    ticks(1);
    chk("wd_busy_fall", busy, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("wd_grant%0d", i), grant, 4'b0000);
      chk($sformatf("wd_start%0d", i), tx_start, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
